shift_add_mult_ctrl: RTL and testbench
======================================

Name: shift_add_mult_ctrl

Overview:
Sequential shift-and-add unsigned multiplier controller. It drives the operand and carry-in pins of the existing combinational 4-bit carry look-ahead adder. It consumes that adder's sum and carry-out and accumulates them over WIDTH iterations to form a 2*WIDTH-bit product. The adder stays a separate instance; this block holds all the state, sequencing and the start/done handshake.

Parameters:
WIDTH, 4, operand width; must match the attached adder width (the CLA is 4 bits).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a multiply; sampled only in IDLE
mcand  input  WIDTH  multiplicand; captured on accepted start
mplier  input  WIDTH  multiplier; captured on accepted start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  single-cycle pulse; product is valid
product  output  2*WIDTH  result; held until the next accepted start
add_a  output  WIDTH  to the adder's a input: the accumulator A
add_b  output  WIDTH  to the adder's b input: M if (state==ADD and Q[0]) else 0
add_cin  output  1  to the adder's c_in; constant 0
add_s  input  WIDTH  from the adder's s output
add_cout  input  1  from the adder's c_out

Behaviour:
- Internal registers:
  - M (WIDTH): multiplicand.
  - Q (WIDTH): multiplier, shifting right.
  - A (WIDTH): accumulator.
  - C (1): carry.
  - cnt (ceil(log2(WIDTH))+1 bits): iterations remaining.
  - state: IDLE, ADD, SHIFT, DONE.
- Reset (rst_n low, asynchronous): state=IDLE, and M, Q, A, C, cnt, product all 0; busy=0, done=0. Reset asserted mid-operation aborts the multiply; no done pulse is issued.
- IDLE:
  - If start=1 at an edge: M<=mcand, Q<=mplier, A<=0, C<=0, cnt<=WIDTH; go to ADD.
  - Otherwise stay in IDLE; product is held.
- ADD:
  - {C,A} <= {add_cout, add_s}; go to SHIFT.
  - When Q[0]=0, add_b=0, so A is reloaded unchanged and C is forced to 0.
- SHIFT:
  - {C,A,Q} <= {1'b0,C,A,Q} >> 1, i.e. C moves into A msb, A lsb moves into Q msb, C<=0.
  - cnt <= cnt-1.
  - If cnt==1 before the decrement: product <= {C,A,Q[WIDTH-1:1]}, i.e. the post-shift {A,Q}, and go to DONE. Otherwise go to ADD.
- DONE: done=1 for exactly one cycle; go to IDLE unconditionally.
- busy = (state != IDLE). done = (state == DONE). Both are decoded from the state register, with no combinational path from inputs.
- Latency: start accepted at edge 0. After edge 2*WIDTH the state is DONE and product is valid, so done is high in that cycle (8 edges for WIDTH=4). After edge 2*WIDTH+1 the block is back in IDLE.
- start while busy is ignored; it is not queued.
- start held high continuously: a new multiply begins at the edge where IDLE is re-entered +1, i.e. back-to-back every 2*WIDTH+2 cycles.
- mcand/mplier changing after acceptance has no effect.
- Arithmetic:
  - Unsigned only; no overflow is possible because the product fits in 2*WIDTH bits.
  - The adder carry-out is always captured into C; it is never dropped.
- add_a is always driven from A. add_cin is always 0. The block assumes the adder settles within one clock period.

Test Plan:
- mcand=15, mplier=15, start pulse -> done high on cycle 8 after acceptance; product=8'hE1 (225); busy high cycles 1-8.
- mcand=9, mplier=6 -> product=8'h36 (54). Check add_b=0 in the first ADD (Q[0]=0) and add_b=9 in the second ADD.
- mcand=0, mplier=13, then mcand=7, mplier=0 -> product=0 both times; done still pulses after exactly 8 cycles.
- start asserted again at cycle 3 of a 5*3 multiply with mcand=2, mplier=2 -> ignored; product=8'h0F. Then start held high -> the next result (2*2=4) completes 10 cycles after the first done.
- rst_n pulled low asynchronously between edges at cycle 5 of 11*13 -> busy, done and product go to 0 immediately with no done pulse. After release, 11*13 -> product=8'h8F (143).
- Carry capture: mcand=15, mplier=1 -> product=8'h0F. Then mcand=12, mplier=3 -> product=8'h24; the ADD of the second bit produces add_cout=1, which must appear in A msb after SHIFT.

Source files
------------

// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier controller. Drives an external
// WIDTH-bit combinational adder and accumulates its result over WIDTH iterations.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_s,
  input  logic               add_cout,
  output logic [1:0]         dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     m_reg;
  logic [WIDTH-1:0]     q_reg;
  logic [WIDTH-1:0]     a_reg;
  logic                 c_reg;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   product_reg;

  // Handshake: start is sampled only in IDLE; once accepted, busy stays high
  // until the DONE cycle, where done pulses for one cycle and product is valid.
  // Further starts while busy are dropped, not queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      m_reg       <= '0;
      q_reg       <= '0;
      a_reg       <= '0;
      c_reg       <= 1'b0;
      cnt         <= '0;
      product_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= mcand;
            q_reg <= mplier;
            a_reg <= '0;
            c_reg <= 1'b0;
            cnt   <= CW'(WIDTH);
            state <= ADD;
          end
        end
        ADD: begin
          // With Q[0]=0 the adder sees b=0, so A reloads unchanged and C clears.
          a_reg <= add_s;
          c_reg <= add_cout;
          state <= SHIFT;
        end
        SHIFT: begin
          a_reg <= {c_reg, a_reg[WIDTH-1:1]};
          q_reg <= {a_reg[0], q_reg[WIDTH-1:1]};
          c_reg <= 1'b0;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            product_reg <= {c_reg, a_reg, q_reg[WIDTH-1:1]};
            state       <= DONE;
          end else begin
            state <= ADD;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign product   = product_reg;
  assign add_a     = a_reg;
  assign add_b     = ((state == ADD) && q_reg[0]) ? m_reg : '0;
  assign add_cin   = 1'b0;
  assign dbg_state = state;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl with a behavioural 4-bit adder attached;
// a monitor pops expected products and done cycles whenever done is seen.
module tb_shift_add_mult_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] mcand;
  logic [3:0] mplier;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_s;
  logic       add_cout;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];

  shift_add_mult_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mcand     (mcand),
    .mplier    (mplier),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .dbg_state (dbg_state)
  );

  // Stand-in for the 4-bit carry look-ahead adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        logic [7:0] e;
        int         ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("product", {24'd0, product}, {24'd0, e});
        check("done_cycle", cyc, ec);
      end
    end
  end

  // Driver tasks
  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    check("drain_idle", {31'd0, (exp_q.size() != 0) || busy}, 32'd0);
  endtask

  task automatic start_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp, input bit push, output int acc);
    wait_idle();
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    acc    = cyc + 1;
    if (push) begin
      exp_q.push_back(exp);
      exp_cyc_q.push_back(acc + 8);
    end
    @(negedge clk);
    start  = 1'b0;
    mcand  = 4'($urandom_range(0, 15));
    mplier = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int acc;
    start  = 1'b0;
    mcand  = 4'd0;
    mplier = 4'd0;
    rst_n  = 1'b0;
    @(negedge clk);
    check("reset_busy",    {31'd0, busy},    32'd0);
    check("reset_done",    {31'd0, done},    32'd0);
    check("reset_product", {24'd0, product}, 32'd0);
    check("reset_add_a",   {28'd0, add_a},   32'd0);
    check("reset_add_b",   {28'd0, add_b},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 15*15 with busy window
    start_op(4'd15, 4'd15, 8'hE1, 1'b1, acc);
    for (int k = 0; k <= 8; k++) begin
      wait_until(acc + k);
      check("busy_window", {31'd0, busy}, 32'd1);
    end
    wait_until(acc + 9);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    wait_idle();

    // 9*6 with adder operand checks
    start_op(4'd9, 4'd6, 8'h36, 1'b1, acc);
    check("add_b_first_add", {28'd0, add_b}, 32'd0);
    check("add_a_first_add", {28'd0, add_a}, 32'd0);
    check("add_cin",         {31'd0, add_cin}, 32'd0);
    wait_until(acc + 2);
    check("add_b_second_add", {28'd0, add_b}, 32'd9);
    wait_idle();

    // zero operands
    start_op(4'd0, 4'd13, 8'h00, 1'b1, acc);
    wait_idle();
    start_op(4'd7, 4'd0, 8'h00, 1'b1, acc);
    wait_idle();

    // carry capture
    start_op(4'd15, 4'd1, 8'h0F, 1'b1, acc);
    wait_idle();
    start_op(4'd12, 4'd3, 8'h24, 1'b1, acc);
    wait_until(acc + 2);
    check("carry_add_cout", {31'd0, add_cout}, 32'd1);
    wait_until(acc + 4);
    check("carry_in_a_msb", {28'd0, add_a}, 32'h9);
    wait_idle();

    // start while busy is ignored, then held high for back-to-back
    start_op(4'd5, 4'd3, 8'h0F, 1'b1, acc);
    wait_until(acc + 3);
    start  = 1'b1;
    mcand  = 4'd2;
    mplier = 4'd2;
    exp_q.push_back(8'h04);
    exp_cyc_q.push_back(acc + 18);
    wait_until(acc + 10);
    start = 1'b0;
    check("restart_busy", {31'd0, busy}, 32'd1);
    wait_idle();

    // asynchronous reset mid-operation
    start_op(4'd11, 4'd13, 8'h00, 1'b0, acc);
    wait_until(acc + 5);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",    {31'd0, busy},    32'd0);
    check("abort_done",    {31'd0, done},    32'd0);
    check("abort_product", {24'd0, product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_stays_idle", {31'd0, busy}, 32'd0);
    start_op(4'd11, 4'd13, 8'h8F, 1'b1, acc);
    wait_idle();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
